pipe_idexe_issue: RTL

//  ID->EXE issue stage: registers decoded ID control and operands into the E-stage registers that drive the execute stage.

---
 rtl/pipe_idexe_issue.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/pipe_idexe_issue.sv
// pipe_idexe_issue: ID->EXE issue stage.
// Registers decoded ID control/operands into the E stage. Resolves RAW hazards
// (by E/M/W forwarding plus a load-use interlock), drives stall back to IF/ID,
// turns stalled or flushed instructions into bubbles and counts stall cycles.
// Optional feature macro: FORWARD_EN. Without it, no operands are forwarded and
// any E/M hazard stalls instead (W is covered by write-before-read in the regfile).
module pipe_idexe_issue #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      dpc4,
    input  logic [31:0]      dqa,
    input  logic [31:0]      dqb,
    input  logic [31:0]      dimm,
    input  logic [4:0]       drs,
    input  logic [4:0]       drt,
    input  logic [4:0]       drn0,
    input  logic [3:0]       daluc,
    input  logic             daluimm,
    input  logic             dshift,
    input  logic             djal,
    input  logic             dwreg,
    input  logic             dm2reg,
    input  logic             dwmem,
    input  logic             duse_rs,
    input  logic             duse_rt,
    input  logic             flush,
    input  logic [31:0]      ealu,
    input  logic [4:0]       mrn,
    input  logic             mwreg,
    input  logic             mm2reg,
    input  logic [31:0]      malu,
    input  logic [31:0]      mmo,
    input  logic [4:0]       wrn,
    input  logic             wwreg,
    input  logic [31:0]      wdi,
    output logic [3:0]       ealuc,
    output logic             ealuimm,
    output logic             eshift,
    output logic             ejal,
    output logic             ewreg,
    output logic             em2reg,
    output logic             ewmem,
    output logic [31:0]      ea,
    output logic [31:0]      eb,
    output logic [31:0]      eimm,
    output logic [31:0]      epc4,
    output logic [4:0]       ern0,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef struct packed {
        logic [3:0]  aluc;
        logic        aluimm;
        logic        shift;
        logic        jal;
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [4:0]  rn0;
    } e_stage_t;

    e_stage_t        e_q, e_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]      ern;
    logic            e_rs, e_rt, m_rs, m_rt;
    logic            hazard, bubble;
    logic [31:0]     fwd_a, fwd_b;

    // A producer matches a source only if it writes, targets a non-zero
    // register and the consumer actually reads that source.
    function automatic logic hit(input logic wr, input logic [4:0] rn,
                                 input logic [4:0] src, input logic used);
        return wr && (rn != 5'd0) && (rn == src) && used;
    endfunction

    // jal writes r31 regardless of the decoded destination
    assign ern  = e_q.rn0 | {5{e_q.jal}};
    assign e_rs = hit(e_q.wreg, ern, drs, duse_rs);
    assign e_rt = hit(e_q.wreg, ern, drt, duse_rt);
    assign m_rs = hit(mwreg, mrn, drs, duse_rs);
    assign m_rt = hit(mwreg, mrn, drt, duse_rt);

`ifdef FORWARD_EN
    logic        w_rs, w_rt;
    logic [31:0] m_val;

    assign w_rs  = hit(wwreg, wrn, drs, duse_rs);
    assign w_rt  = hit(wwreg, wrn, drt, duse_rt);
    assign m_val = mm2reg ? mmo : malu;

    // Only a load sitting in E cannot be forwarded in time
    assign hazard = (e_rs | e_rt) & e_q.m2reg;

    // Youngest producer wins; a load in E is never the forward source
    always_comb begin
        fwd_a = dqa;
        if (e_rs && !e_q.m2reg) fwd_a = ealu;
        else if (m_rs)          fwd_a = m_val;
        else if (w_rs)          fwd_a = wdi;
        fwd_b = dqb;
        if (e_rt && !e_q.m2reg) fwd_b = ealu;
        else if (m_rt)          fwd_b = m_val;
        else if (w_rt)          fwd_b = wdi;
    end
`else
    // Forwarding sources are idle in this build
    logic unused_fwd;
    assign unused_fwd = ^{ealu, malu, mmo, mm2reg, wrn, wwreg, wdi};

    // Wait out every in-flight E/M producer; W writes the regfile first
    assign hazard = e_rs | e_rt | m_rs | m_rt;
    assign fwd_a  = dqa;
    assign fwd_b  = dqb;
`endif

    // flush wins over stall, and nothing stalls while in reset
    assign stall  = ~reset & ~flush & hazard;
    assign bubble = stall | flush;

    // Next E contents: decoded instruction, or an all-zero bubble
    always_comb begin
        e_d = '0;
        if (!bubble) begin
            e_d.aluc   = daluc;
            e_d.aluimm = daluimm;
            e_d.shift  = dshift;
            e_d.jal    = djal;
            e_d.wreg   = dwreg;
            e_d.m2reg  = dm2reg;
            e_d.wmem   = dwmem;
            e_d.a      = fwd_a;
            e_d.b      = fwd_b;     // store data even for immediate ops
            e_d.imm    = dimm;
            e_d.pc4    = dpc4;
            e_d.rn0    = drn0;
        end
        cnt_d = cnt_q;
        if (stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    end

    // E-stage and stall counter registers, synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            e_q   <= '0;
            cnt_q <= '0;
        end else begin
            e_q   <= e_d;
            cnt_q <= cnt_d;
        end
    end

    assign ealuc     = e_q.aluc;
    assign ealuimm   = e_q.aluimm;
    assign eshift    = e_q.shift;
    assign ejal      = e_q.jal;
    assign ewreg     = e_q.wreg;
    assign em2reg    = e_q.m2reg;
    assign ewmem     = e_q.wmem;
    assign ea        = e_q.a;
    assign eb        = e_q.b;
    assign eimm      = e_q.imm;
    assign epc4      = e_q.pc4;
    assign ern0      = e_q.rn0;
    assign stall_cnt = cnt_q;

endmodule
